pipe_add: RTL

// - Parametrised, pipelined carry-lookahead adder/subtractor/incrementor for the datapath.
// - Generalises the combinational 16/64-bit CL adders and incrementors:
//   - any width that is a multiple of a chunk;
//   - one chunk resolved per pipeline stage, carry registered between stages;
//   - valid/ready flow control and status flags.
// - Sits between operand registers and the ALU result mux; one operation accepted per cycle.

---
 rtl/pipe_add.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipe_add.sv
// Pipelined carry-lookahead add/sub/inc/adc: one CHUNK resolved per stage, carry registered
// between stages, upper operand chunks skewed in and finished low chunks deskewed out.
module pipe_add #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16,
    localparam int NSTAGE = WIDTH / CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    // Handshake: a beat moves when valid & ready on the same rising edge; the whole pipe
    // advances together (adv), so a stalled output freezes every stage and the input.
    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    logic [WIDTH-1:0] b_cond;
    logic             c0;

    always_comb begin
        b_cond = b;
        c0     = 1'b0;
        case (op)
            2'b00: begin b_cond = b;  c0 = 1'b0; end
            2'b01: begin b_cond = ~b; c0 = 1'b1; end
            2'b10: begin b_cond = '0; c0 = 1'b1; end
            default: begin b_cond = b; c0 = cin; end
        endcase
    end

    // Stage k keeps only the operand chunks still to be added and the sum chunks already done.
    for (genvar k = 0; k < NSTAGE - 1; k++) begin : g_stage
        localparam int REM = WIDTH - (k + 1) * CHUNK;

        logic [REM-1:0]           a_r, b_r;
        logic [(k+1)*CHUNK-1:0]   s_r;
        logic                     c_r, v_r;

        logic [REM+CHUNK-1:0]     a_in, b_in;
        logic                     c_in, v_in;
        logic [CHUNK:0]           csum;
        logic [(k+1)*CHUNK-1:0]   s_nx;

        if (k == 0) begin : g_first
            assign a_in = a;
            assign b_in = b_cond;
            assign c_in = c0;
            assign v_in = in_valid;
            assign s_nx = csum[CHUNK-1:0];
        end else begin : g_mid
            assign a_in = g_stage[k-1].a_r;
            assign b_in = g_stage[k-1].b_r;
            assign c_in = g_stage[k-1].c_r;
            assign v_in = g_stage[k-1].v_r;
            assign s_nx = {csum[CHUNK-1:0], g_stage[k-1].s_r};
        end

        assign csum = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, c_in};

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                a_r <= '0;
                b_r <= '0;
                s_r <= '0;
                c_r <= 1'b0;
                v_r <= 1'b0;
            end else if (adv) begin
                a_r <= a_in[REM+CHUNK-1:CHUNK];
                b_r <= b_in[REM+CHUNK-1:CHUNK];
                s_r <= s_nx;
                c_r <= csum[CHUNK];
                v_r <= v_in;
            end
        end
    end

    // Final chunk: split off the MSB so the carry into it is visible for signed overflow.
    logic [CHUNK-1:0]       a_l, b_l;
    logic [WIDTH-CHUNK-1:0] s_l;
    logic                   c_l, v_l;
    logic [CHUNK-1:0]       lo;
    logic [1:0]             hi;
    logic [WIDTH-1:0]       sum_nx;

    assign a_l = g_stage[NSTAGE-2].a_r;
    assign b_l = g_stage[NSTAGE-2].b_r;
    assign s_l = g_stage[NSTAGE-2].s_r;
    assign c_l = g_stage[NSTAGE-2].c_r;
    assign v_l = g_stage[NSTAGE-2].v_r;

    assign lo     = {1'b0, a_l[CHUNK-2:0]} + {1'b0, b_l[CHUNK-2:0]}
                  + {{(CHUNK-1){1'b0}}, c_l};
    assign hi     = {1'b0, a_l[CHUNK-1]} + {1'b0, b_l[CHUNK-1]} + {1'b0, lo[CHUNK-1]};
    assign sum_nx = {hi[0], lo[CHUNK-2:0], s_l};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (adv) begin
            out_valid <= v_l;
            sum       <= sum_nx;
            cout      <= hi[1];
            ovf       <= hi[1] ^ lo[CHUNK-1];
            zero      <= (sum_nx == '0);
        end
    end

endmodule
